// File: rtl/uart_cmd_decoder_if.sv
// Bundle of the decoder's byte-stream input and its key / framed-payload / echo outputs.
// master: the decoder itself; slave: the UART receiver / cipher-core side.
interface uart_cmd_decoder_if #(
    parameter int KEY_W = 32
);
    logic [7:0]       rx_data;
    logic             rx_data_rdy;
    logic [KEY_W-1:0] key;
    logic             key_vld;
    logic             mode;
    logic             msg_start;
    logic [7:0]       byte_out;
    logic             byte_out_vld;
    logic             msg_end;
    logic             err;
    logic [7:0]       tx_data;
    logic             tx_data_rdy;

    modport master (
        input  rx_data, rx_data_rdy,
        output key, key_vld, mode, msg_start, byte_out, byte_out_vld,
        output msg_end, err, tx_data, tx_data_rdy
    );

    modport slave (
        output rx_data, rx_data_rdy,
        input  key, key_vld, mode, msg_start, byte_out, byte_out_vld,
        input  msg_end, err, tx_data, tx_data_rdy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ASCII command parser between the UART receiver and the cipher core.
//   L<hex digits><CR>  load key
//   E<text><CR>        plaintext message, bytes passed through
//   D<hex pairs><CR>   ciphertext message, hex pairs packed into bytes
// All outputs are registered, one cycle after the accepted rx byte.
// Optional feature: define CMD_ECHO_EN to echo received bytes on tx_data/tx_data_rdy
// (CR echoed as CR followed by LF). Without it tx_data/tx_data_rdy are tied to 0.
module uart_cmd_decoder #(
    parameter int KEY_DIGITS = 8,
    parameter int MAX_MSG    = 256
) (
    input  logic              clk12m,
    input  logic              rst,
    uart_cmd_decoder_if.master bus
);
    localparam int KEY_W = 4 * KEY_DIGITS;
    localparam int KC_W  = $clog2(KEY_DIGITS + 2);
    localparam int MC_W  = $clog2(MAX_MSG + 1);
    localparam logic [KC_W-1:0] KCNT_FULL = KC_W'(KEY_DIGITS);
    localparam logic [KC_W-1:0] KCNT_SAT  = KC_W'(KEY_DIGITS + 1);
    localparam logic [MC_W-1:0] MSG_LIMIT = MC_W'(MAX_MSG);

    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_LF = 8'h0a;
    localparam logic [7:0] CH_L  = 8'h4c;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_D  = 8'h44;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_ENC,
        ST_DEC_HI,
        ST_DEC_LO
    } state_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_nib(input logic [7:0] c);
        logic [7:0] v;
        if (c >= 8'h61)      v = c - 8'h57;
        else if (c >= 8'h41) v = c - 8'h37;
        else                 v = c - 8'h30;
        return v[3:0];
    endfunction

    state_t           state_q, state_d;
    logic [KEY_W-1:0] sr_q, sr_d;
    logic [KC_W-1:0]  kcnt_q, kcnt_d;
    logic             bad_q, bad_d;
    logic [3:0]       hi_q, hi_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic             ovf_q, ovf_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_vld_q, key_vld_d;
    logic             mode_q, mode_d;
    logic             msg_start_q, msg_start_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_out_vld_q, byte_out_vld_d;
    logic             msg_end_q, msg_end_d;
    logic             err_q, err_d;

    logic             pay_en;
    logic [7:0]       pay_byte;
    logic             act;
    logic [7:0]       rx;

    assign rx  = bus.rx_data;
    assign act = bus.rx_data_rdy && (bus.rx_data != CH_LF);

    // Next-state and output decode for the command parser
    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        kcnt_d         = kcnt_q;
        bad_d          = bad_q;
        hi_d           = hi_q;
        mcnt_d         = mcnt_q;
        ovf_d          = ovf_q;
        key_d          = key_q;
        mode_d         = mode_q;
        byte_out_d     = byte_out_q;
        key_vld_d      = 1'b0;
        msg_start_d    = 1'b0;
        byte_out_vld_d = 1'b0;
        msg_end_d      = 1'b0;
        err_d          = 1'b0;
        pay_en         = 1'b0;
        pay_byte       = 8'h00;

        if (act) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx == CH_L) begin
                        state_d = ST_KEY;
                        sr_d    = '0;
                        kcnt_d  = '0;
                        bad_d   = 1'b0;
                    end else if (rx == CH_E || rx == CH_D) begin
                        state_d     = (rx == CH_E) ? ST_ENC : ST_DEC_HI;
                        mode_d      = (rx == CH_D);
                        msg_start_d = 1'b1;
                        mcnt_d      = '0;
                        ovf_d       = 1'b0;
                    end else if (rx != CH_CR) begin
                        err_d = 1'b1;
                    end
                end
                ST_KEY: begin
                    if (rx == CH_CR) begin
                        if (kcnt_q == KCNT_FULL && !bad_q) begin
                            key_d     = sr_q;
                            key_vld_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else if (is_hex(rx)) begin
                        sr_d = {sr_q[KEY_W-5:0], hex_nib(rx)};
                        if (kcnt_q != KCNT_SAT) kcnt_d = kcnt_q + 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
                ST_ENC: begin
                    if (rx == CH_CR) begin
                        msg_end_d = 1'b1;
                        err_d     = ovf_q;
                        state_d   = ST_IDLE;
                    end else begin
                        pay_en   = 1'b1;
                        pay_byte = rx;
                    end
                end
                ST_DEC_HI: begin
                    if (rx == CH_CR) begin
                        msg_end_d = 1'b1;
                        err_d     = ovf_q;
                        state_d   = ST_IDLE;
                    end else if (is_hex(rx)) begin
                        hi_d    = hex_nib(rx);
                        state_d = ST_DEC_LO;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DEC_LO: begin
                    // A dangling high nibble at CR is an odd digit count: always an error
                    if (rx == CH_CR) begin
                        msg_end_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (is_hex(rx)) begin
                        pay_en   = 1'b1;
                        pay_byte = {hi_q, hex_nib(rx)};
                        state_d  = ST_DEC_HI;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Payload bytes beyond MAX_MSG are dropped and remembered for the CR error
        if (pay_en) begin
            if (mcnt_q < MSG_LIMIT) begin
                byte_out_d     = pay_byte;
                byte_out_vld_d = 1'b1;
                mcnt_d         = mcnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Parser state and output registers
    always_ff @(posedge clk12m) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sr_q           <= '0;
            kcnt_q         <= '0;
            bad_q          <= 1'b0;
            hi_q           <= 4'h0;
            mcnt_q         <= '0;
            ovf_q          <= 1'b0;
            key_q          <= '0;
            key_vld_q      <= 1'b0;
            mode_q         <= 1'b0;
            msg_start_q    <= 1'b0;
            byte_out_q     <= 8'h00;
            byte_out_vld_q <= 1'b0;
            msg_end_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            kcnt_q         <= kcnt_d;
            bad_q          <= bad_d;
            hi_q           <= hi_d;
            mcnt_q         <= mcnt_d;
            ovf_q          <= ovf_d;
            key_q          <= key_d;
            key_vld_q      <= key_vld_d;
            mode_q         <= mode_d;
            msg_start_q    <= msg_start_d;
            byte_out_q     <= byte_out_d;
            byte_out_vld_q <= byte_out_vld_d;
            msg_end_q      <= msg_end_d;
            err_q          <= err_d;
        end
    end

    assign bus.key          = key_q;
    assign bus.key_vld      = key_vld_q;
    assign bus.mode         = mode_q;
    assign bus.msg_start    = msg_start_q;
    assign bus.byte_out     = byte_out_q;
    assign bus.byte_out_vld = byte_out_vld_q;
    assign bus.msg_end      = msg_end_q;
    assign bus.err          = err_q;

`ifdef CMD_ECHO_EN
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_rdy_q, tx_rdy_d;
    logic       lf_pend_q, lf_pend_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    // Echo arbitration: queued LF first, then a byte parked behind it, then fresh rx
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_rdy_d   = 1'b0;
        lf_pend_d  = 1'b0;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (lf_pend_q) begin
            tx_data_d = CH_LF;
            tx_rdy_d  = 1'b1;
            if (bus.rx_data_rdy) begin
                hold_d     = rx;
                hold_vld_d = 1'b1;
            end
        end else if (hold_vld_q) begin
            tx_data_d  = hold_q;
            tx_rdy_d   = 1'b1;
            lf_pend_d  = (hold_q == CH_CR);
            hold_vld_d = bus.rx_data_rdy;
            if (bus.rx_data_rdy) hold_d = rx;
        end else if (bus.rx_data_rdy) begin
            tx_data_d = rx;
            tx_rdy_d  = 1'b1;
            lf_pend_d = (rx == CH_CR);
        end
    end

    // Echo registers
    always_ff @(posedge clk12m) begin
        if (rst) begin
            tx_data_q  <= 8'h00;
            tx_rdy_q   <= 1'b0;
            lf_pend_q  <= 1'b0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_rdy_q   <= tx_rdy_d;
            lf_pend_q  <= lf_pend_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_data_rdy = tx_rdy_q;
`else
    assign bus.tx_data     = 8'h00;
    assign bus.tx_data_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: table of per-byte vectors with expected
// registered outputs, plus sequences for reset, message overflow and echo.
module tb_uart_cmd_decoder;
    localparam logic [7:0] CR = 8'h0d;
    localparam logic [7:0] LF = 8'h0a;

    logic clk12m = 1'b0;
    logic rst;

    always #5 clk12m = ~clk12m;

    uart_cmd_decoder_if #(.KEY_W(32)) bus ();

    uart_cmd_decoder #(.KEY_DIGITS(8), .MAX_MSG(256)) dut (
        .clk12m (clk12m),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0]  d;
        logic        kv;
        logic [31:0] k;
        logic        md;
        logic        ms;
        logic        bv;
        logic [7:0]  b;
        logic        me;
        logic        er;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_key  = 32'h0;
    logic        exp_mode = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tx_bad   = 0;
    logic [7:0]  txq[$];

    task automatic check(input string nm, input logic [63:0] actual, input logic [63:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, actual, required);
        end
    endtask

    task automatic add(input logic [7:0] dd, input logic kv, input logic ms, input logic bv,
                       input logic [7:0] b, input logic me, input logic er);
        vec_t v;
        v.d = dd; v.kv = kv; v.k = exp_key; v.md = exp_mode; v.ms = ms;
        v.bv = bv; v.b = b; v.me = me; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic quiet(input logic [7:0] dd);
        add(dd, 0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic quiet_s(input string s);
        for (int i = 0; i < s.len(); i++) quiet(s[i]);
    endtask

    task automatic key_ok(input logic [31:0] k);
        exp_key = k;
        add(CR, 1, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic start(input logic [7:0] dd, input logic md);
        exp_mode = md;
        add(dd, 0, 1, 0, 8'h00, 0, 0);
    endtask

    task automatic pay(input logic [7:0] dd, input logic [7:0] b);
        add(dd, 0, 0, 1, b, 0, 0);
    endtask

    task automatic done(input logic er);
        add(CR, 0, 0, 0, 8'h00, 1, er);
    endtask

    task automatic perr(input logic [7:0] dd);
        add(dd, 0, 0, 0, 8'h00, 0, 1);
    endtask

    // Drive one byte at a falling edge; return at the next falling edge with its response visible
    task automatic send(input logic [7:0] dd);
        bus.rx_data     = dd;
        bus.rx_data_rdy = 1'b1;
        @(negedge clk12m);
        bus.rx_data_rdy = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {19'h0, bus.key_vld, bus.key, bus.mode, bus.msg_start, bus.byte_out_vld,
                bus.byte_out, bus.msg_end, bus.err};
    endfunction

    task automatic run_msg(input int n);
        int cnt;
        int exp_cnt;
        send("E");
        check($sformatf("ovf%0d_start", n), {62'h0, bus.msg_start, bus.mode}, 64'h2);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            send(8'h41 + 8'(i % 26));
            if (bus.byte_out_vld) cnt++;
        end
        send(CR);
        exp_cnt = (n > 256) ? 256 : n;
        check($sformatf("ovf%0d_end", n), {62'h0, bus.msg_end, bus.err}, {62'h0, 1'b1, (n > 256)});
        check($sformatf("ovf%0d_cnt", n), 64'(cnt), 64'(exp_cnt));
    endtask

`ifdef CMD_ECHO_EN
    always @(negedge clk12m) if (bus.tx_data_rdy) txq.push_back(bus.tx_data);
`else
    always @(negedge clk12m) if (bus.tx_data_rdy || bus.tx_data != 8'h00) tx_bad++;
`endif

    initial begin
        logic [63:0] act_v;
        logic [63:0] exp_v;
        logic        mm;

        rst             = 1'b1;
        bus.rx_data     = 8'h00;
        bus.rx_data_rdy = 1'b0;
        repeat (3) @(negedge clk12m);
        check("reset", all_outs(), 64'h0);
        rst = 1'b0;

        // Key load, LF/CR in idle, plaintext, ciphertext
        quiet_s("L12345678"); key_ok(32'h12345678);
        quiet(LF); quiet(CR);
        start("E", 0); pay("a", 8'h61); pay("b", 8'h62); pay("c", 8'h63);
        pay("d", 8'h64); pay("!", 8'h21); done(0);
        start("D", 1); quiet("f"); pay("0", 8'hf0); quiet("c"); pay("0", 8'hc0);
        quiet("2"); pay("7", 8'h27); quiet("6"); pay("c", 8'h6c);
        quiet("b"); pay("0", 8'hb0); done(0);
        // Bad key loads keep the old key
        quiet_s("L123"); perr(CR);
        quiet_s("LZ12345678"); perr(CR);
        quiet_s("L123456789"); perr(CR);
        quiet_s("LaBcDeF01"); key_ok(32'habcdef01);
        // Odd digit count, junk in idle, non-hex in both nibble states, LF inside messages
        start("D", 1); quiet("a"); pay("b", 8'hab); quiet("c"); done(1);
        perr("x");
        start("D", 1); perr("g"); quiet("1"); quiet(LF); pay("2", 8'h12);
        quiet("3"); perr("z"); pay("4", 8'h34); done(0);
        start("E", 0); pay("Z", 8'h5a); quiet(LF); pay(" ", 8'h20); done(0);

        foreach (tbl[i]) begin
            send(tbl[i].d);
            mm    = tbl[i].ms | tbl[i].bv;
            act_v = {19'h0, bus.key_vld, bus.key, mm ? bus.mode : 1'b0, bus.msg_start,
                     bus.byte_out_vld, tbl[i].bv ? bus.byte_out : 8'h00, bus.msg_end, bus.err};
            exp_v = {19'h0, tbl[i].kv, tbl[i].k, mm ? tbl[i].md : 1'b0, tbl[i].ms,
                     tbl[i].bv, tbl[i].bv ? tbl[i].b : 8'h00, tbl[i].me, tbl[i].er};
            check($sformatf("vec%0d_%0h", i, tbl[i].d), act_v, exp_v);
        end

        // Reset in the middle of a key load, with a byte arriving in the same cycle
        send("L"); send("1"); send("2");
        rst             = 1'b1;
        bus.rx_data     = "3";
        bus.rx_data_rdy = 1'b1;
        @(negedge clk12m);
        bus.rx_data_rdy = 1'b0;
        rst             = 1'b0;
        check("rst_mid", all_outs(), 64'h0);
        send("L");
        for (int i = 0; i < 7; i++) send("0");
        send("1");
        send(CR);
        check("key_after_rst", {31'h0, bus.key_vld, bus.key}, {31'h0, 1'b1, 32'h1});

        // Message length boundary: exactly MAX_MSG, then past it
        run_msg(256);
        run_msg(300);

`ifdef CMD_ECHO_EN
        txq.delete();
        send("E"); @(negedge clk12m);
        send("1"); @(negedge clk12m);
        send(CR);  repeat (3) @(negedge clk12m);
        check("echo_len", 64'(txq.size()), 64'd4);
        if (txq.size() == 4) begin
            check("echo0", 64'(txq[0]), 64'h45);
            check("echo1", 64'(txq[1]), 64'h31);
            check("echo2", 64'(txq[2]), 64'h0d);
            check("echo3", 64'(txq[3]), 64'h0a);
        end
`else
        repeat (2) @(negedge clk12m);
        check("tx_idle", 64'(tx_bad), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
